// File: rtl/sdrc_cfg_regs_if.sv
// Request/acknowledge register bus between a config master and sdrc_cfg_regs.
// One-cycle access strobe in, one-cycle acknowledge with read data and error out.
interface sdrc_cfg_regs_if;
  logic        reg_req;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack;
  logic [31:0] reg_rdata;
  logic        reg_err;

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata,
    input  reg_ack, reg_rdata, reg_err
  );

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata,
    output reg_ack, reg_rdata, reg_err
  );
endinterface

// File: rtl/sdrc_cfg_regs.sv
// SDRC configuration register bank with enable sequencer and timing-register lock.
// Define SDRC_CFG_TIMEOUT_EN to add the init timeout counter and the FAULT state.
module sdrc_cfg_regs #(
  parameter int unsigned SDR_REFRESH_TIMER_W   = 12,
  parameter int unsigned SDR_REFRESH_ROW_CNT_W = 3,
  parameter logic [15:0] INIT_TIMEOUT          = 16'd50000
) (
  input  logic                             sdram_clk,
  input  logic                             sdram_resn,
  sdrc_cfg_regs_if.slave                   bus,
  output logic [1:0]                       cfg_sdr_width,
  output logic [1:0]                       cfg_colbits,
  output logic [3:0]                       cfg_sdr_tras_d,
  output logic [3:0]                       cfg_sdr_trp_d,
  output logic [3:0]                       cfg_sdr_trcd_d,
  output logic                             cfg_sdr_en,
  output logic [1:0]                       cfg_req_depth,
  output logic [12:0]                      cfg_sdr_mode_reg,
  output logic [2:0]                       cfg_sdr_cas,
  output logic [3:0]                       cfg_sdr_trcar_d,
  output logic [3:0]                       cfg_sdr_twr_d,
  output logic [SDR_REFRESH_TIMER_W-1:0]   cfg_sdr_rfsh,
  output logic [SDR_REFRESH_ROW_CNT_W-1:0] cfg_sdr_rfmax,
  input  logic                             sdr_init_done,
  output logic                             cfg_irq
);

  typedef enum logic [1:0] {
    StDisabled = 2'd0,
    StEnabling = 2'd1,
    StReady    = 2'd2,
    StFault    = 2'd3
  } state_e;

  state_e state_q;

  logic        wr, ctrl_on, ctrl_off, lockable, cfg_wr, timeout_hit;
  logic [31:0] rd_val;
  logic        ack_q, err_q;
  logic [31:0] rdata_q;

  logic [12:0] mode_q;
  logic [3:0]  tras_q, trp_q, trcd_q, trcar_q, twr_q;
  logic [2:0]  cas_q;
  logic [1:0]  width_q, colbits_q, depth_q;
  logic [SDR_REFRESH_TIMER_W-1:0]   rfsh_q;
  logic [SDR_REFRESH_ROW_CNT_W-1:0] rfmax_q;

  logic unused_wdata;
  assign unused_wdata = ^bus.reg_wdata[31:16];

  assign wr       = bus.reg_req & bus.reg_we;
  assign ctrl_on  = wr & (bus.reg_addr == 3'd0) & bus.reg_wdata[0];
  assign ctrl_off = wr & (bus.reg_addr == 3'd0) & ~bus.reg_wdata[0];
  assign lockable = (bus.reg_addr >= 3'd2) && (bus.reg_addr <= 3'd6);
  assign cfg_wr   = wr & lockable & (state_q == StDisabled);

`ifdef SDRC_CFG_TIMEOUT_EN
  logic [15:0] cnt_q;

  // Counts cycles spent in ENABLING; the FAULT edge is the INIT_TIMEOUT-th one.
  always_ff @(posedge sdram_clk or negedge sdram_resn) begin
    if (!sdram_resn) begin
      cnt_q <= 16'd0;
    end else if (state_q == StDisabled && ctrl_on) begin
      cnt_q <= 16'd0;
    end else if (state_q == StEnabling) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign timeout_hit = ((cnt_q + 16'd1) == INIT_TIMEOUT);
`else
  logic unused_timeout;
  assign unused_timeout = ^INIT_TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // Disable wins over everything; init_done wins over a same-cycle timeout.
  always_ff @(posedge sdram_clk or negedge sdram_resn) begin
    if (!sdram_resn) begin
      state_q <= StDisabled;
    end else if (ctrl_off) begin
      state_q <= StDisabled;
    end else begin
      case (state_q)
        StDisabled: if (ctrl_on) state_q <= StEnabling;
        StEnabling: begin
          if (sdr_init_done)    state_q <= StReady;
          else if (timeout_hit) state_q <= StFault;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = 32'd0;
    case (bus.reg_addr)
      3'd1: rd_val = {28'd0, state_q, (state_q == StFault), sdr_init_done};
      3'd2: rd_val = {19'd0, mode_q};
      3'd3: rd_val = {16'd0, trcar_q, trcd_q, trp_q, tras_q};
      3'd4: rd_val = {19'd0, depth_q, colbits_q, width_q, cas_q, twr_q};
      3'd5: rd_val = 32'(rfsh_q);
      3'd6: rd_val = 32'(rfmax_q);
      default: rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resn) begin
    if (!sdram_resn) begin
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      ack_q   <= bus.reg_req;
      rdata_q <= (bus.reg_req && !bus.reg_we) ? rd_val : 32'd0;
      err_q   <= wr & lockable & (state_q != StDisabled);
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resn) begin
    if (!sdram_resn) begin
      mode_q    <= 13'h033;
      tras_q    <= 4'd4;
      trp_q     <= 4'd2;
      trcd_q    <= 4'd2;
      trcar_q   <= 4'd7;
      twr_q     <= 4'd1;
      cas_q     <= 3'd3;
      width_q   <= 2'b10;
      colbits_q <= 2'd0;
      depth_q   <= 2'd3;
      rfsh_q    <= SDR_REFRESH_TIMER_W'('h100);
      rfmax_q   <= SDR_REFRESH_ROW_CNT_W'(6);
    end else if (cfg_wr) begin
      case (bus.reg_addr)
        3'd2: mode_q <= bus.reg_wdata[12:0];
        3'd3: begin
          tras_q  <= bus.reg_wdata[3:0];
          trp_q   <= bus.reg_wdata[7:4];
          trcd_q  <= bus.reg_wdata[11:8];
          trcar_q <= bus.reg_wdata[15:12];
        end
        3'd4: begin
          twr_q     <= bus.reg_wdata[3:0];
          cas_q     <= bus.reg_wdata[6:4];
          width_q   <= bus.reg_wdata[8:7];
          colbits_q <= bus.reg_wdata[10:9];
          depth_q   <= bus.reg_wdata[12:11];
        end
        3'd5: rfsh_q  <= bus.reg_wdata[SDR_REFRESH_TIMER_W-1:0];
        3'd6: rfmax_q <= bus.reg_wdata[SDR_REFRESH_ROW_CNT_W-1:0];
        default: ;
      endcase
    end
  end

  assign bus.reg_ack   = ack_q;
  assign bus.reg_rdata = rdata_q;
  assign bus.reg_err   = err_q;

  assign cfg_sdr_en       = (state_q == StEnabling) || (state_q == StReady);
  assign cfg_irq          = (state_q == StReady) || (state_q == StFault);
  assign cfg_sdr_mode_reg = mode_q;
  assign cfg_sdr_tras_d   = tras_q;
  assign cfg_sdr_trp_d    = trp_q;
  assign cfg_sdr_trcd_d   = trcd_q;
  assign cfg_sdr_trcar_d  = trcar_q;
  assign cfg_sdr_twr_d    = twr_q;
  assign cfg_sdr_cas      = cas_q;
  assign cfg_sdr_width    = width_q;
  assign cfg_colbits      = colbits_q;
  assign cfg_req_depth    = depth_q;
  assign cfg_sdr_rfsh     = rfsh_q;
  assign cfg_sdr_rfmax    = rfmax_q;

endmodule

// File: tb/tb_sdrc_cfg_regs.sv
// Bench for sdrc_cfg_regs: directed scenarios plus random bus traffic against an
// access-level model of the register map and enable sequencer.
module tb_sdrc_cfg_regs;
  localparam logic [15:0] Timeout = 16'd100;
`ifdef SDRC_CFG_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic resn = 1'b0;
  logic init_done = 1'b0;
  always #5 clk = ~clk;

  sdrc_cfg_regs_if bus ();

  logic [1:0]  cfg_sdr_width, cfg_colbits, cfg_req_depth;
  logic [3:0]  cfg_sdr_tras_d, cfg_sdr_trp_d, cfg_sdr_trcd_d, cfg_sdr_trcar_d, cfg_sdr_twr_d;
  logic        cfg_sdr_en, cfg_irq;
  logic [12:0] cfg_sdr_mode_reg;
  logic [2:0]  cfg_sdr_cas;
  logic [11:0] cfg_sdr_rfsh;
  logic [2:0]  cfg_sdr_rfmax;

  sdrc_cfg_regs #(
    .SDR_REFRESH_TIMER_W  (12),
    .SDR_REFRESH_ROW_CNT_W(3),
    .INIT_TIMEOUT         (Timeout)
  ) dut (
    .sdram_clk       (clk),
    .sdram_resn      (resn),
    .bus             (bus),
    .cfg_sdr_width   (cfg_sdr_width),
    .cfg_colbits     (cfg_colbits),
    .cfg_sdr_tras_d  (cfg_sdr_tras_d),
    .cfg_sdr_trp_d   (cfg_sdr_trp_d),
    .cfg_sdr_trcd_d  (cfg_sdr_trcd_d),
    .cfg_sdr_en      (cfg_sdr_en),
    .cfg_req_depth   (cfg_req_depth),
    .cfg_sdr_mode_reg(cfg_sdr_mode_reg),
    .cfg_sdr_cas     (cfg_sdr_cas),
    .cfg_sdr_trcar_d (cfg_sdr_trcar_d),
    .cfg_sdr_twr_d   (cfg_sdr_twr_d),
    .cfg_sdr_rfsh    (cfg_sdr_rfsh),
    .cfg_sdr_rfmax   (cfg_sdr_rfmax),
    .sdr_init_done   (init_done),
    .cfg_irq         (cfg_irq)
  );

  int checks = 0;
  int errors = 0;

  // Model: state 0 DISABLED, 1 ENABLING, 2 READY, 3 FAULT; registers kept as map words.
  int          m_state;
  int          m_cycles;
  logic [12:0] m_mode;
  logic [15:0] m_tim0;
  logic [12:0] m_tim1;
  logic [11:0] m_rfsh;
  logic [2:0]  m_rfmax;
  logic        e_ack, e_err;
  logic [31:0] e_rdata;

  task automatic model_reset();
    m_state  = 0;
    m_cycles = 0;
    m_mode   = 13'h033;
    m_tim0   = 16'h7224;
    m_tim1   = 13'h1931;
    m_rfsh   = 12'h100;
    m_rfmax  = 3'd6;
    e_ack    = 1'b0;
    e_err    = 1'b0;
    e_rdata  = 32'd0;
  endtask

  function automatic logic [31:0] m_read(input int a);
    case (a)
      1: return 32'(m_state * 4 + ((m_state == 3) ? 2 : 0) + int'(init_done));
      2: return 32'(m_mode);
      3: return 32'(m_tim0);
      4: return 32'(m_tim1);
      5: return 32'(m_rfsh);
      6: return 32'(m_rfmax);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit req, input bit we, input int addr, input logic [31:0] wd);
    bit writable;
    writable = req && we && addr >= 2 && addr <= 6;
    e_ack   = req;
    e_rdata = (req && !we) ? m_read(addr) : 32'd0;
    e_err   = writable && (m_state != 0);
    if (writable && m_state == 0) begin
      case (addr)
        2: m_mode  = wd[12:0];
        3: m_tim0  = wd[15:0];
        4: m_tim1  = wd[12:0];
        5: m_rfsh  = wd[11:0];
        default: m_rfmax = wd[2:0];
      endcase
    end
    if (req && we && addr == 0 && !wd[0]) begin
      m_state = 0;
    end else if (m_state == 0 && req && we && addr == 0) begin
      m_state  = 1;
      m_cycles = 0;
    end else if (m_state == 1) begin
      if (init_done) begin
        m_state = 2;
      end else begin
        m_cycles++;
        if (TimeoutEn && m_cycles == int'(Timeout)) m_state = 3;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ack", 32'(bus.reg_ack), 32'(e_ack));
    check("rdata", bus.reg_rdata, e_rdata);
    check("err", 32'(bus.reg_err), 32'(e_err));
    check("sdr_en", 32'(cfg_sdr_en), 32'(m_state == 1 || m_state == 2));
    check("irq", 32'(cfg_irq), 32'(m_state == 2 || m_state == 3));
    check("mode", 32'(cfg_sdr_mode_reg), 32'(m_mode));
    check("tim0", {16'd0, cfg_sdr_trcar_d, cfg_sdr_trcd_d, cfg_sdr_trp_d, cfg_sdr_tras_d},
          32'(m_tim0));
    check("tim1", {19'd0, cfg_req_depth, cfg_colbits, cfg_sdr_width, cfg_sdr_cas, cfg_sdr_twr_d},
          32'(m_tim1));
    check("rfsh", 32'(cfg_sdr_rfsh), 32'(m_rfsh));
    check("rfmax", 32'(cfg_sdr_rfmax), 32'(m_rfmax));
  endtask

  // Drive one access (or idle) from a negedge, step the model at the edge, check next negedge.
  task automatic tick(input bit req, input bit we, input int addr, input logic [31:0] wd);
    bus.reg_req   = req;
    bus.reg_we    = we;
    bus.reg_addr  = 3'(addr);
    bus.reg_wdata = wd;
    @(posedge clk);
    model_step(req, we, addr, wd);
    @(negedge clk);
    bus.reg_req = 1'b0;
    check_all();
  endtask

  initial begin
    bus.reg_req   = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = 3'd0;
    bus.reg_wdata = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    resn = 1'b1;
    check_all();

    // Reset defaults through the bus
    tick(1, 0, 2, 0);
    check("mode_rd", bus.reg_rdata, 32'h033);
    tick(1, 0, 1, 0);
    check("status_rst", bus.reg_rdata, 32'h0);

    // Program then enable
    tick(1, 1, 3, 32'h7224);
    tick(1, 1, 5, 32'h180);
    tick(1, 1, 0, 32'h1);
    check("en_on", 32'(cfg_sdr_en), 32'd1);
    repeat (20) tick(0, 0, 0, 0);
    init_done = 1'b1;
    tick(0, 0, 0, 0);
    tick(1, 0, 1, 0);
    check("status_ready", bus.reg_rdata, 32'h9);
    check("irq_ready", 32'(cfg_irq), 32'd1);

    // Lock while enabled, unlock after disable
    tick(1, 1, 4, 32'h1FFF);
    check("lock_err", 32'(bus.reg_err), 32'd1);
    check("lock_cas", 32'(cfg_sdr_cas), 32'd3);
    tick(1, 1, 0, 32'h0);
    tick(1, 1, 4, 32'h0011);
    check("unlock_twr", 32'(cfg_sdr_twr_d), 32'd1);
    check("unlock_cas", 32'(cfg_sdr_cas), 32'd1);
    check("unlock_err", 32'(bus.reg_err), 32'd0);
    init_done = 1'b0;

`ifdef SDRC_CFG_TIMEOUT_EN
    tick(1, 1, 0, 32'h1);
    repeat (int'(Timeout) - 1) tick(0, 0, 0, 0);
    check("pre_fault_en", 32'(cfg_sdr_en), 32'd1);
    tick(0, 0, 0, 0);
    check("fault_en", 32'(cfg_sdr_en), 32'd0);
    tick(1, 0, 1, 0);
    check("status_fault", bus.reg_rdata, 32'hE);
    tick(1, 1, 0, 32'h1);
    tick(1, 0, 1, 0);
    check("fault_sticky", bus.reg_rdata, 32'hE);
    tick(1, 1, 0, 32'h0);
    tick(1, 0, 1, 0);
    check("fault_exit", bus.reg_rdata, 32'h0);
`endif

    // Width truncation and reserved address
    tick(1, 1, 6, 32'hFF);
    check("rfmax_trunc", 32'(cfg_sdr_rfmax), 32'd7);
    tick(1, 0, 6, 0);
    check("rfmax_rd", bus.reg_rdata, 32'h7);
    tick(1, 1, 7, 32'hFFFF_FFFF);
    check("rsvd_err", 32'(bus.reg_err), 32'd0);
    tick(1, 0, 7, 0);
    check("rsvd_rd", bus.reg_rdata, 32'h0);

    // Random traffic, including back-to-back requests and init_done wiggle
    for (int i = 0; i < 400; i++) begin
      bit          rq, w;
      int          a;
      logic [31:0] d;
      if ($urandom_range(0, 11) == 0) init_done = ~init_done;
      rq = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      a  = $urandom_range(0, 7);
      d  = $urandom;
      if (a == 0 && $urandom_range(0, 2) != 0) a = 4;
      tick(rq, w, a, d);
    end

    // Asynchronous reset in ENABLING, away from any clock edge
    init_done = 1'b0;
    tick(1, 1, 0, 32'h0);
    tick(1, 1, 0, 32'h1);
    check("pre_rst_en", 32'(cfg_sdr_en), 32'd1);
    #2 resn = 1'b0;
    #1;
    model_reset();
    check("async_en", 32'(cfg_sdr_en), 32'd0);
    check("async_ack", 32'(bus.reg_ack), 32'd0);
    check_all();
    @(negedge clk);
    resn = 1'b1;
    tick(1, 0, 1, 0);
    check("status_after_rst", bus.reg_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
